// File: rtl/branch_compare_pkg.sv
// Shared definitions for the branch-compare path: condition codes, FSM encoding,
// and the single condition-code-to-result mapping used by the decoder and branch unit.
package branch_compare_pkg;

    localparam logic [2:0] CC_LT = 3'b000;
    localparam logic [2:0] CC_GT = 3'b001;
    localparam logic [2:0] CC_LE = 3'b010;
    localparam logic [2:0] CC_GE = 3'b011;
    localparam logic [2:0] CC_NE = 3'b100;
    localparam logic [2:0] CC_EQ = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic result;
        logic illegal;
    } cond_t;

    // Codes 101 and 111 are reserved: report illegal and a false outcome.
    function automatic cond_t eval_cond(input logic [2:0] comp,
                                        input logic       less,
                                        input logic       equal);
        cond_t r;
        r.result  = 1'b0;
        r.illegal = 1'b0;
        case (comp)
            CC_LT:   r.result = less;
            CC_GT:   r.result = ~less & ~equal;
            CC_LE:   r.result = less | equal;
            CC_GE:   r.result = ~less;
            CC_EQ:   r.result = equal;
            CC_NE:   r.result = ~equal;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_compare_chunk.sv
// One CHUNK-bit unsigned magnitude compare; flip_msb turns it into a signed
// compare by biasing the sign bit of both operands.
module compare_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             flip_msb,
    output logic             lt,
    output logic             eq
);

    localparam logic [CHUNK-1:0] MSB = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] x_m;
    logic [CHUNK-1:0] y_m;

    assign x_m = flip_msb ? (x ^ MSB) : x;
    assign y_m = flip_msb ? (y ^ MSB) : y;
    assign lt  = x_m < y_m;
    assign eq  = x == y;

endmodule

// File: rtl/branch_compare.sv
// Multi-cycle branch comparator: scans operands one chunk per cycle from the
// most significant end and stops at the first differing chunk.
module branch_compare
    import branch_compare_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       comp,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             less,
    output logic             equal,
    output logic             illegal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       comp_q, comp_d;
    logic             signed_q, signed_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;
    logic             result_q, result_d;
    logic             illegal_q, illegal_d;

    logic [CHUNK-1:0] chunk_a, chunk_b;
    logic             chunk_lt, chunk_eq;
    logic             fin_less;
    cond_t            fin_cond;

    assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

    compare_chunk #(.CHUNK(CHUNK)) u_chunk (
        .x        (chunk_a),
        .y        (chunk_b),
        .flip_msb (signed_q && (idx_q == IDX_TOP)),
        .lt       (chunk_lt),
        .eq       (chunk_eq)
    );

    // Only meaningful on the cycle the scan terminates.
    assign fin_less = chunk_eq ? 1'b0 : chunk_lt;
    assign fin_cond = eval_cond(comp_q, fin_less, chunk_eq);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        comp_d    = comp_q;
        signed_d  = signed_q;
        less_d    = less_q;
        equal_d   = equal_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    comp_d   = comp;
                    signed_d = is_signed;
                    idx_d    = IDX_TOP;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!chunk_eq || (idx_q == '0)) begin
                    less_d    = fin_less;
                    equal_d   = chunk_eq;
                    result_d  = fin_cond.result;
                    illegal_d = fin_cond.illegal;
                    state_d   = ST_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            result_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    // NOTE: operand holding registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        comp_q   <= comp_d;
        signed_q <= signed_d;
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign less      = less_q;
    assign equal     = equal_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_branch_compare.sv
// Directed and randomized checks of branch_compare with CHUNK=8 (inst 0)
// and CHUNK=WIDTH=32 (inst 1) sharing one clock and reset.
module tb_branch_compare;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  in_valid = '0;
    logic [1:0]  out_ready = '0;
    logic [1:0]  is_signed = '0;
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [2:0]  comp [2];
    logic [1:0]  in_ready, out_valid, result, less, equal, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_compare #(.WIDTH(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .comp(comp[0]), .is_signed(is_signed[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]),
        .less(less[0]), .equal(equal[0]), .illegal(illegal[0])
    );

    branch_compare #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .comp(comp[1]), .is_signed(is_signed[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]),
        .less(less[1]), .equal(equal[1]), .illegal(illegal[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: chunks scanned from the top until the first difference.
    function automatic int ref_lat(input logic [31:0] av, input logic [31:0] bv, input int ck);
        logic [63:0] mask;
        int n;
        mask = (64'd1 << ck) - 64'd1;
        n = 32 / ck;
        for (int i = n - 1; i >= 0; i--) begin
            if (((64'(av) >> (i * ck)) & mask) != ((64'(bv) >> (i * ck)) & mask))
                return (n - i) + 1;
        end
        return n + 1;
    endfunction

    function automatic logic ref_less(input logic [31:0] av, input logic [31:0] bv, input logic sv);
        return sv ? ($signed(av) < $signed(bv)) : (av < bv);
    endfunction

    function automatic logic [1:0] ref_cond(input logic [2:0] cv, input logic l, input logic e);
        case (cv)
            3'b000:  return {l, 1'b0};
            3'b001:  return {!l && !e, 1'b0};
            3'b010:  return {l || e, 1'b0};
            3'b011:  return {!l, 1'b0};
            3'b110:  return {e, 1'b0};
            3'b100:  return {!e, 1'b0};
            default: return 2'b01;
        endcase
    endfunction

    // One full transaction on instance k; during stalls and the transfer cycle
    // a competing request is offered and must be ignored.
    task automatic run_req(input int k, input logic [31:0] av, input logic [31:0] bv,
                           input logic [2:0] cv, input logic sv, input int stall,
                           input int e_lat, input logic e_less, input logic e_eq,
                           input logic e_res, input logic e_ill, input string tag);
        int lat;
        int guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready[k] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "/in_ready"}, 32'(in_ready[k]), 32'd1);
        a[k] = av; b[k] = bv; comp[k] = cv; is_signed[k] = sv; in_valid[k] = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        a[k] = ~av; b[k] = av; comp[k] = ~cv; is_signed[k] = ~sv;
        while (!out_valid[k] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "/latency"}, 32'(lat), 32'(e_lat));
        check({tag, "/less"},    32'(less[k]),    32'(e_less));
        check({tag, "/equal"},   32'(equal[k]),   32'(e_eq));
        check({tag, "/result"},  32'(result[k]),  32'(e_res));
        check({tag, "/illegal"}, 32'(illegal[k]), 32'(e_ill));
        for (int i = 0; i < stall; i++) begin
            in_valid[k] = 1'b1;
            a[k] = $urandom; b[k] = $urandom;
            @(posedge clk);
            @(negedge clk);
            check({tag, "/hold"}, {28'd0, result[k], less[k], equal[k], illegal[k]},
                  {28'd0, e_res, e_less, e_eq, e_ill});
            check({tag, "/stall_valid"}, {30'd0, out_valid[k], in_ready[k]}, 32'b10);
        end
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        in_valid[k] = 1'b0;
        check({tag, "/after_xfer"}, {30'd0, out_valid[k], in_ready[k]}, 32'b01);
    endtask

    task automatic run_model(input int k, input logic [31:0] av, input logic [31:0] bv,
                             input logic [2:0] cv, input logic sv, input int stall, input string tag);
        logic       l;
        logic       e;
        logic [1:0] c;
        l = ref_less(av, bv, sv);
        e = (av == bv);
        c = ref_cond(cv, l, e);
        run_req(k, av, bv, cv, sv, stall, ref_lat(av, bv, (k == 0) ? 8 : 32), l, e, c[1], c[0], tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       seen_valid;
        logic [31:0] ra, rb;
        for (int k = 0; k < 2; k++) begin
            a[k] = '0; b[k] = '0; comp[k] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset_outputs", {26'd0, out_valid, result, less}, 32'd0);
        check("reset_flags",   {28'd0, equal, illegal}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'b11);

        // k lat less eq res ill
        run_req(0, 32'h0000_0005, 32'h0000_0007, 3'b000, 1'b0, 0, 5, 1, 0, 1, 0, "lt_u");
        run_req(0, 32'h8000_0000, 32'h0000_0001, 3'b001, 1'b0, 0, 2, 0, 0, 1, 0, "gt_u");
        run_req(0, 32'h8000_0000, 32'h0000_0001, 3'b001, 1'b1, 0, 2, 1, 0, 0, 0, "gt_s");
        run_req(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b110, 1'b0, 0, 5, 0, 1, 1, 0, "eq");
        run_req(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b100, 1'b0, 0, 5, 0, 1, 0, 0, "ne");
        run_req(0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b101, 1'b0, 3, 5, 0, 1, 0, 1, "ill101_stall");
        run_req(0, 32'h1234_5678, 32'h1234_5600, 3'b011, 1'b0, 0, 5, 0, 0, 1, 0, "ge_low");
        run_req(0, 32'h7FFF_FFFF, 32'h8000_0000, 3'b000, 1'b1, 0, 2, 0, 0, 0, 0, "lt_s_ext");
        run_req(0, 32'hFFFF_FFFF, 32'h0000_0000, 3'b010, 1'b1, 0, 2, 1, 0, 1, 0, "le_s");
        run_req(1, 32'h0000_0005, 32'h0000_0007, 3'b000, 1'b0, 0, 2, 1, 0, 1, 0, "c32_lt");
        run_req(1, 32'h8000_0000, 32'h0000_0001, 3'b001, 1'b1, 2, 2, 1, 0, 0, 0, "c32_gt_s");
        run_req(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'b111, 1'b0, 0, 2, 0, 1, 0, 1, "c32_ill111");

        // Reset in the second SCAN cycle discards the request.
        @(negedge clk);
        a[0] = 32'h0000_0005; b[0] = 32'h0000_0007; comp[0] = 3'b000; is_signed[0] = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {28'd0, out_valid[0], result[0], less[0], equal[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen_valid = 1'b1;
        end
        check("rst_no_valid", 32'(seen_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);
        run_req(0, 32'h0000_0001, 32'h0000_0002, 3'b011, 1'b0, 0, 5, 1, 0, 0, 0, "post_rst_ge");

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 25; n++) begin
                ra = $urandom;
                case ($urandom_range(0, 3))
                    0:       rb = $urandom;
                    1:       rb = ra;
                    2:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
                    default: rb = ra ^ 32'h8000_0000;
                endcase
                run_model(k, ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3), $sformatf("rnd%0d_%0d", k, n));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_compare.md
BRANCH_COMPARE -- requirements
Module: branch_compare

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL provide parameter CHUNK, default 8, bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept a request.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 comp  input  3  condition code.
REQ-009 is_signed  input  1  1 = two's-complement compare, 0 = unsigned.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 result  output  1  condition outcome.
REQ-013 less, equal  output  1 each  raw relation a<b, a==b.
REQ-014 illegal  output  1  comp was not a defined code.

Function
REQ-015 Condition codes: 000 LT=less; 001 GT=~less&~equal; 010 LE=less|equal; 011 GE=~less; 110 EQ=equal; 100 NE=~equal.
REQ-016 Codes 101 and 111 SHALL give result=0, illegal=1; less/equal still valid; never drive Z.
REQ-017 FSM states IDLE, SCAN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-018 IDLE: in_valid=1 latches a, b, comp, is_signed, sets chunk index idx=NCHUNK-1, moves to SCAN.
REQ-019 SCAN: each cycle compares chunk idx (bits idx*CHUNK+CHUNK-1 .. idx*CHUNK) of latched a and b.
REQ-020 For idx=NCHUNK-1 with is_signed=1, the top bit of each chunk SHALL be inverted before the unsigned chunk compare.
REQ-021 Chunks differ: less=(chunk_a<chunk_b), equal=0, go DONE (early termination).
REQ-022 Chunks equal and idx=0: less=0, equal=1, go DONE; else idx decrements, stay SCAN.
REQ-023 Latency, accept edge to out_valid: 1 + (number of chunks scanned) cycles; minimum 2, maximum NCHUNK+1.
REQ-024 DONE: result, less, equal, illegal SHALL be held stable while out_valid=1 and out_ready=0.
REQ-025 DONE with out_ready=1: transfer completes that edge, next state IDLE; no new request is accepted in that same cycle.
REQ-026 Inputs a, b, comp, is_signed are ignored outside the IDLE accept cycle.
REQ-027 CHUNK=WIDTH SHALL be legal: every request takes exactly 2 cycles.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, idx=0, out_valid=0, result=0, less=0, equal=0, illegal=0; in_ready=1 once rst deasserts.
REQ-029 Reset during SCAN or DONE SHALL discard the in-flight request with no out_valid pulse.

Structure
REQ-030 A shared package SHALL hold the condition-code constants (LT, GT, LE, GE, EQ, NE) and the FSM state encoding, for reuse by the decoder and branch unit.
REQ-031 A combinational sub-module compare_chunk (parameter CHUNK; inputs x, y, flip_msb; outputs lt, eq) SHALL implement one chunk compare.
REQ-032 Condition-code-to-result mapping SHALL be a function in the package, not duplicated.

Verification
REQ-033 WIDTH=32, CHUNK=8, unsigned, a=0x00000005, b=0x00000007, comp=000 -> 4 chunks scanned, out_valid 5 cycles after accept, less=1, equal=0, result=1.
REQ-034 a=0x80000000, b=0x00000001, comp=001: is_signed=0 -> early exit after 1 chunk, latency 2, result=1; is_signed=1 -> less=1, result=0.
REQ-035 a=b=0xDEADBEEF, comp=110 then comp=100 -> latency 5, equal=1, result=1 then 0; comp=101 -> illegal=1, result=0.
REQ-036 Hold out_ready=0 for 3 cycles in DONE -> outputs stable, in_ready=0; in_valid pulsed during DONE -> request not accepted.
REQ-037 Assert rst in 2nd SCAN cycle -> out_valid never rises, in_ready=1 after release; next request a=1, b=2, comp=011 -> result=0.
REQ-038 Random back-to-back requests with random out_ready stalls, both CHUNK=8 and CHUNK=32 -> every result matches reference model, none lost or duplicated.
